// File: rtl/char_match.sv
// rtl/char_match.sv - glyph template matcher: best XNOR-popcount score over NUM_TMPL 16x16 templates.
// Optional reject flag is built only when CHAR_MATCH_REJECT_EN is defined.
module char_match #(
  parameter int         NUM_TMPL      = 10,
  parameter logic [8:0] REJECT_THRESH = 9'd200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  tmpl_sel,
  output logic [3:0]  row_addr,
  input  logic [0:15] tmpl_row,
  input  logic [0:15] samp_row,
  output logic [3:0]  best_digit,
  output logic [8:0]  best_score,
  output logic        reject
);

  localparam logic [3:0] LAST_TMPL = 4'(NUM_TMPL - 1);

  if (NUM_TMPL < 1 || NUM_TMPL > 16) begin : g_bad_num_tmpl
    $error("char_match: NUM_TMPL must be 1..16");
  end
  if (REJECT_THRESH > 9'd256) begin : g_bad_thresh
    $error("char_match: REJECT_THRESH must be 0..256");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t     state;
  logic       drain_cnt;
  logic       rd_valid;
  logic [3:0] rd_tmpl;
  logic [3:0] rd_row;
  logic [8:0] acc;
  logic [8:0] best_int;
  logic [3:0] best_idx;
  logic [4:0] row_score;
  logic [8:0] new_sum;

  // Row 0 of each template starts a fresh sum, so the accumulator never needs a dead cycle.
  always_comb begin
    row_score = '0;
    for (int i = 0; i < 16; i++) begin
      row_score = row_score + 5'(~(tmpl_row[i] ^ samp_row[i]));
    end
    new_sum = ((rd_row == 4'd0) ? 9'd0 : acc) + 9'(row_score);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_cnt  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tmpl_sel   <= '0;
      row_addr   <= '0;
      best_digit <= '0;
      best_score <= '0;
`ifdef CHAR_MATCH_REJECT_EN
      reject     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            tmpl_sel <= '0;
            row_addr <= '0;
          end
        end
        SCAN: begin
          if (row_addr == 4'd15) begin
            row_addr <= '0;
            if (tmpl_sel == LAST_TMPL) begin
              tmpl_sel  <= '0;
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end else begin
              tmpl_sel <= tmpl_sel + 4'd1;
            end
          end else begin
            row_addr <= row_addr + 4'd1;
          end
        end
        DRAIN: begin
          // Two cycles: one for the read latency, one for the last accumulate/compare.
          if (drain_cnt) begin
            state      <= DONE;
            done       <= 1'b1;
            best_digit <= best_idx;
            best_score <= best_int;
`ifdef CHAR_MATCH_REJECT_EN
            reject     <= (best_int < REJECT_THRESH);
`endif
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_tmpl  <= '0;
      rd_row   <= '0;
      acc      <= '0;
      best_int <= '0;
      best_idx <= '0;
    end else begin
      rd_valid <= (state == SCAN);
      rd_tmpl  <= tmpl_sel;
      rd_row   <= row_addr;
      if (rd_valid) begin
        acc <= new_sum;
        // Strictly greater keeps the lower index on ties; template 0 always seeds the best.
        if (rd_row == 4'd15 && (rd_tmpl == 4'd0 || new_sum > best_int)) begin
          best_int <= new_sum;
          best_idx <= rd_tmpl;
        end
      end
    end
  end

`ifndef CHAR_MATCH_REJECT_EN
  assign reject = 1'b0;
`endif

endmodule

// File: tb/tb_char_match.sv
// tb/tb_char_match.sv - self-checking bench for char_match (NUM_TMPL=10 and NUM_TMPL=1 instances).
module tb_char_match;

  localparam int NT   = 10;
  localparam int LAST = 16 * NT + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start1;
  logic        busy, done, busy1, done1;
  logic [3:0]  tmpl_sel, row_addr, tsel1, raddr1;
  logic [0:15] tmpl_row, samp_row, trow1, srow1;
  logic [3:0]  best_digit, bd1;
  logic [8:0]  best_score, bs1;
  logic        reject, rej1;

  logic [0:15] tmem [16][16];
  logic [0:15] smem [16];

  int vectors = 0;
  int miscompares = 0;
  int exp_d, exp_s, exp_r;

  always #5 clk = ~clk;

  char_match #(.NUM_TMPL(NT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .tmpl_sel(tmpl_sel), .row_addr(row_addr), .tmpl_row(tmpl_row), .samp_row(samp_row),
    .best_digit(best_digit), .best_score(best_score), .reject(reject)
  );

  char_match #(.NUM_TMPL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .tmpl_sel(tsel1), .row_addr(raddr1), .tmpl_row(trow1), .samp_row(srow1),
    .best_digit(bd1), .best_score(bs1), .reject(rej1)
  );

  // Glyph ROM bank and image buffer with one cycle of read latency.
  always @(posedge clk) begin
    tmpl_row <= tmem[tmpl_sel][row_addr];
    samp_row <= smem[row_addr];
    trow1    <= tmem[tsel1][raddr1];
    srow1    <= smem[raddr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [0:15] glyph4(input int r);
    logic [0:15] g;
    g = '0;
    if (r >= 2 && r <= 9)  begin g[3] = 1'b1;  g[4] = 1'b1;  end
    if (r >= 2 && r <= 13) begin g[10] = 1'b1; g[11] = 1'b1; end
    if (r == 9 || r == 10) for (int c = 3; c <= 12; c++) g[c] = 1'b1;
    return g;
  endfunction

  function automatic int expect_reject(input int score);
`ifdef CHAR_MATCH_REJECT_EN
    return (score < 200) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Reference: total matching pixels per template, first best wins ties.
  task automatic model(input int ntmpl);
    int sc;
    exp_d = 0;
    exp_s = -1;
    for (int t = 0; t < ntmpl; t++) begin
      sc = 0;
      for (int r = 0; r < 16; r++) sc += 16 - $countones(tmem[t][r] ^ smem[r]);
      if (sc > exp_s) begin exp_s = sc; exp_d = t; end
    end
    exp_r = expect_reject(exp_s);
  endtask

  task automatic load_glyph_case();
    for (int t = 0; t < 16; t++)
      for (int r = 0; r < 16; r++) tmem[t][r] = (t == 4) ? glyph4(r) : 16'h0;
    for (int r = 0; r < 16; r++) smem[r] = glyph4(r);
  endtask

  // One pass: start sampled at the edge ending cycle 0; checks every cycle through done.
  task automatic run_pass(input string tag, input bit repulse, input bit start_on_done,
                          input int abort_at);
    int dones;
    logic [9:0] exp_ctl;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= LAST; c++) begin
      exp_ctl = {1'b1, (c == LAST), (c <= 16*NT) ? 4'((c-1)/16) : 4'd0,
                 (c <= 16*NT) ? 4'((c-1)%16) : 4'd0};
      check({tag, "_ctl"}, {22'd0, busy, done, tmpl_sel, row_addr}, {22'd0, exp_ctl});
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_outs"},
              {8'd0, busy, done, tmpl_sel, row_addr, best_digit, best_score, reject}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 200; k++) begin
          @(posedge clk); #1;
          if (done || busy) dones++;
        end
        check({tag, "_no_done_after_rst"}, dones, 0);
        return;
      end
      if (c == LAST) begin
        check({tag, "_digit"}, best_digit, exp_d);
        check({tag, "_score"}, best_score, exp_s);
        check({tag, "_reject"}, reject, exp_r);
      end
      start = (repulse && (c == 5 || c == 100)) || (start_on_done && c == LAST);
      @(posedge clk); #1;
    end
    start = 1'b0;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy || done) dones++;
      @(posedge clk); #1;
    end
    check({tag, "_idle_after"}, dones, 0);
    check({tag, "_hold"}, {best_digit, best_score, reject}, {4'(exp_d), 9'(exp_s), 1'(exp_r)});
  endtask

  initial begin
    int cnt, k, dones;
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    load_glyph_case();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {8'd0, busy, done, tmpl_sel, row_addr, best_digit, best_score, reject}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Matching digit-4 sample.
    exp_d = 4; exp_s = 256; exp_r = 0;
    run_pass("glyph4", 1'b0, 1'b0, 0);

    // Everything blank: all tie at 256, lowest index wins.
    for (int t = 0; t < 16; t++) for (int r = 0; r < 16; r++) tmem[t][r] = '0;
    for (int r = 0; r < 16; r++) smem[r] = '0;
    exp_d = 0; exp_s = 256; exp_r = 0;
    run_pass("all_zero", 1'b0, 1'b0, 0);

    // Digit 4 with 100 background pixels set.
    load_glyph_case();
    cnt = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (!smem[r][c] && cnt < 100) begin smem[r][c] = 1'b1; cnt++; end
    exp_d = 4; exp_s = 156; exp_r = expect_reject(156);
    run_pass("noisy4", 1'b0, 1'b0, 0);

    // Start re-pulsed mid-pass and on the done cycle must be ignored.
    load_glyph_case();
    exp_d = 4; exp_s = 256; exp_r = 0;
    run_pass("repulse", 1'b1, 1'b1, 0);

    // Reset at cycle 50, then a clean pass on the noisy sample.
    run_pass("abort", 1'b0, 1'b0, 50);
    cnt = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (!smem[r][c] && cnt < 100) begin smem[r][c] = 1'b1; cnt++; end
    exp_d = 4; exp_s = 156; exp_r = expect_reject(156);
    run_pass("after_abort", 1'b0, 1'b0, 0);

    // Random templates; sample is a lightly corrupted copy of one of them.
    for (int p = 0; p < 5; p++) begin
      for (int t = 0; t < 16; t++) for (int r = 0; r < 16; r++) tmem[t][r] = 16'($urandom);
      k = $urandom_range(NT - 1);
      for (int r = 0; r < 16; r++) smem[r] = tmem[k][r] ^ 16'(1 << $urandom_range(15));
      if (p == 4) for (int r = 0; r < 16; r++) smem[r] = 16'($urandom);
      model(NT);
      run_pass("random", 1'b0, 1'b0, 0);
    end

    // Single-template instance.
    for (int r = 0; r < 16; r++) begin tmem[0][r] = 16'($urandom); smem[r] = tmem[0][r]; end
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    dones = 0;
    for (int c = 1; c <= 19; c++) begin
      check("n1_ctl", {busy1, done1}, {1'b1, (c == 19)});
      if (c == 19) begin
        check("n1_digit", bd1, 0);
        check("n1_score", bs1, 256);
        check("n1_reject", rej1, 0);
      end
      @(posedge clk); #1;
    end
    check("n1_idle", {busy1, done1}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/char_match.md
CHAR_MATCH -- requirements
Module: char_match

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter NUM_TMPL, default 10: number of digit templates scanned; legal range 1..16.
REQ-003 Parameter REJECT_THRESH, default 200: minimum accepted best score; 9 bits wide; used only under CHAR_MATCH_REJECT_EN.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle request to begin a recognition pass.
REQ-007 busy  out  1  high while a pass is in progress.
REQ-008 done  out  1  one-cycle pulse when results are updated.
REQ-009 tmpl_sel  out  4  template (digit) index presented to the glyph ROM bank.
REQ-010 row_addr  out  4  row address; drives both the template ROM and the sample image buffer.
REQ-011 tmpl_row  in  16  template row bits, [0:15] order, with bit 0 as the leftmost pixel.
REQ-012 samp_row  in  16  binarized captured-image row bits, in the same order as tmpl_row.
REQ-013 best_digit  out  4  index of the best-matching template.
REQ-014 best_score  out  9  matching-pixel count of the best template, 0..256.
REQ-015 reject  out  1  best_score below REJECT_THRESH; tied to 0 when the feature is absent.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN, DRAIN and DONE.
REQ-017 IDLE->SCAN SHALL occur on start=1.
REQ-018 SCAN SHALL last 16*NUM_TMPL cycles and then go to DRAIN.
REQ-019 DRAIN SHALL last 2 cycles and then go to DONE.
REQ-020 DONE SHALL last 1 cycle and then go to IDLE.
REQ-021 tmpl_sel and row_addr SHALL be registered outputs that step (tmpl,row) = (0,0),(0,1)..(0,15),(1,0).. with one step per SCAN cycle.
REQ-022 Both tmpl_sel and row_addr SHALL hold 0 outside SCAN.
REQ-023 Read latency SHALL be taken as one cycle: tmpl_row and samp_row are sampled the cycle after the address is presented, so both combinational and 1-cycle registered sources are supported.
REQ-024 The per-row score SHALL be the popcount of XNOR(tmpl_row, samp_row), range 0..16.
REQ-025 Per-row scores SHALL be accumulated per template into a 9-bit sum; 16 rows give 0..256, so overflow is impossible.
REQ-026 After a template's 16th row is accumulated, its sum SHALL replace the running best only if it is strictly greater, so ties keep the lower digit index.
REQ-027 The template-0 sum SHALL always initialise the best.
REQ-028 The accumulator SHALL clear at each template boundary without losing a cycle.
REQ-029 best_digit, best_score and reject SHALL update only in DONE, coincident with the done pulse.
REQ-030 Those outputs SHALL hold their values until the next DONE.
REQ-031 Latency: if start is sampled in cycle 0, done SHALL be high in cycle 16*NUM_TMPL+3 and busy SHALL be high in cycles 1..16*NUM_TMPL+3.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 start coincident with the done cycle SHALL be ignored; a new pass requires start while in IDLE.

Reset
REQ-034 rst_n=0 SHALL asynchronously force the IDLE state at any point, including mid-scan.
REQ-035 rst_n=0 SHALL force all of busy, done, tmpl_sel, row_addr, best_digit, best_score, reject and the internal accumulators to 0.
REQ-036 No partial result SHALL be published after a reset; the next pass restarts from template 0.

Configuration
REQ-037 When the macro CHAR_MATCH_REJECT_EN is defined, reject SHALL be computed in DONE as (best score < REJECT_THRESH).
REQ-038 When CHAR_MATCH_REJECT_EN is undefined, the reject port SHALL still exist, SHALL be constant 0, and no comparator logic SHALL be generated.

Verification
REQ-039 Template stub returns the digit-4 glyph for sel=4 and all-zero rows otherwise; sample = digit-4 glyph -> done in cycle 163, best_digit=4, best_score=256.
REQ-040 All templates and the sample all-zero -> every template scores 256 -> best_digit=0 (tie rule), best_score=256.
REQ-041 Sample = digit-4 glyph with 100 pixels flipped, REJECT_EN defined -> best_digit=4, best_score=156, reject=1; with the macro undefined -> reject=0.
REQ-042 start re-pulsed at cycles 5 and 100 of a pass -> exactly one done pulse at cycle 163; tmpl_sel/row_addr sequence is unperturbed.
REQ-043 rst_n pulsed low at cycle 50 of a pass -> all outputs 0 immediately, no done pulse; a fresh start yields the correct result 163 cycles later.
REQ-044 NUM_TMPL=1, matching sample -> done at cycle 19, best_digit=0, best_score=256.
